// File: rtl/alu_arb_pkg.sv
// Shared types and select widths for the two-requester ALU arbiter.
package alu_arb_pkg;

  localparam int N_REQ      = 2;
  localparam int MUX1_SEL_W = 1;
  localparam int MUX2_SEL_W = 2;
  localparam int OP_SEL_W   = 3;
  localparam int PC_SEL_W   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_arb_state_e;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, shared-ALU and response bundle between two requesters, the arbiter and the ALU.
interface alu_arbiter_if #(
  parameter int W = 32,
  parameter int P = 12
);
  import alu_arb_pkg::*;

  // Handshakes: a beat transfers on a rising edge where valid and ready are both 1.
  // valid may drop before its transfer; ready never depends on a later cycle.
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ*W-1:0]          req_opd1;
  logic [N_REQ*W-1:0]          req_opd2;
  logic [N_REQ*W-1:0]          req_opd3;
  logic [N_REQ*W-1:0]          req_opd4;
  logic [N_REQ*P-1:0]          req_pc;
  logic [N_REQ*MUX1_SEL_W-1:0] req_mux1_sel;
  logic [N_REQ*MUX2_SEL_W-1:0] req_mux2_sel;
  logic [N_REQ*OP_SEL_W-1:0]   req_op_sel;
  logic [N_REQ*PC_SEL_W-1:0]   req_pc_sel;

  logic [W-1:0]                alu_opd1;
  logic [W-1:0]                alu_opd2;
  logic [W-1:0]                alu_opd3;
  logic [W-1:0]                alu_opd4;
  logic [P-1:0]                alu_pc;
  logic [MUX1_SEL_W-1:0]       alu_mux1_select;
  logic [MUX2_SEL_W-1:0]       alu_mux2_select;
  logic [OP_SEL_W-1:0]         alu_op_select;
  logic [PC_SEL_W-1:0]         alu_pc_select;
  logic [W-1:0]                alu_result;
  logic [W-1:0]                comp_result;

  logic [N_REQ-1:0]            rsp_valid;
  logic [N_REQ-1:0]            rsp_ready;
  logic [W-1:0]                rsp_result;
  logic [W-1:0]                rsp_comp;

  modport slave (
    input  req_valid, req_opd1, req_opd2, req_opd3, req_opd4, req_pc,
           req_mux1_sel, req_mux2_sel, req_op_sel, req_pc_sel,
           alu_result, comp_result, rsp_ready,
    output req_ready, alu_opd1, alu_opd2, alu_opd3, alu_opd4, alu_pc,
           alu_mux1_select, alu_mux2_select, alu_op_select, alu_pc_select,
           rsp_valid, rsp_result, rsp_comp
  );

  modport master (
    output req_valid, req_opd1, req_opd2, req_opd3, req_opd4, req_pc,
           req_mux1_sel, req_mux2_sel, req_op_sel, req_pc_sel,
           alu_result, comp_result, rsp_ready,
    input  req_ready, alu_opd1, alu_opd2, alu_opd3, alu_opd4, alu_pc,
           alu_mux1_select, alu_mux2_select, alu_op_select, alu_pc_select,
           rsp_valid, rsp_result, rsp_comp
  );

endinterface

// File: rtl/alu_arbiter_rr.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not served last.
module rr_arbiter_2 (
  input  logic [1:0] valid,
  input  logic [0:0] last,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  always_comb begin
    gnt = 2'b00;
    case (valid)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last[0] ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  assign gnt_idx = gnt[1];

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: grant, issue, capture, respond (3 cycles/op).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int OPERAND_LENGTH = 32,
  parameter int PC_LENGTH      = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_arbiter_if.slave   bus,
  output alu_arb_state_e dbg_state
);

  localparam int W = OPERAND_LENGTH;
  localparam int P = PC_LENGTH;

  alu_arb_state_e        state;
  logic [0:0]            last_q;
  logic                  owner_q;
  logic [N_REQ-1:0]      gnt;
  logic                  gnt_idx;
  logic                  accept;
  logic                  rsp_fire;

  logic [W-1:0]          sel_opd1;
  logic [W-1:0]          sel_opd2;
  logic [W-1:0]          sel_opd3;
  logic [W-1:0]          sel_opd4;
  logic [P-1:0]          sel_pc;
  logic [MUX1_SEL_W-1:0] sel_mux1;
  logic [MUX2_SEL_W-1:0] sel_mux2;
  logic [OP_SEL_W-1:0]   sel_op;
  logic [PC_SEL_W-1:0]   sel_pcs;

  logic [W-1:0]          iss_opd1;
  logic [W-1:0]          iss_opd2;
  logic [W-1:0]          iss_opd3;
  logic [W-1:0]          iss_opd4;
  logic [P-1:0]          iss_pc;
  logic [MUX1_SEL_W-1:0] iss_mux1;
  logic [MUX2_SEL_W-1:0] iss_mux2;
  logic [OP_SEL_W-1:0]   iss_op;
  logic [PC_SEL_W-1:0]   iss_pcs;

  logic [N_REQ-1:0]      rsp_valid_q;
  logic [W-1:0]          rsp_result_q;
  logic [W-1:0]          rsp_comp_q;

  rr_arbiter_2 u_rr (
    .valid   (bus.req_valid),
    .last    (last_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Ready is held low during reset so no request looks accepted while the block is cleared.
  assign bus.req_ready = (state == IDLE && rst_n) ? gnt : '0;
  assign accept        = |(bus.req_valid & bus.req_ready);
  assign rsp_fire      = (state == RESP) && bus.rsp_ready[owner_q];

  always_comb begin
    sel_opd1 = bus.req_opd1[W-1:0];
    sel_opd2 = bus.req_opd2[W-1:0];
    sel_opd3 = bus.req_opd3[W-1:0];
    sel_opd4 = bus.req_opd4[W-1:0];
    sel_pc   = bus.req_pc[P-1:0];
    sel_mux1 = bus.req_mux1_sel[MUX1_SEL_W-1:0];
    sel_mux2 = bus.req_mux2_sel[MUX2_SEL_W-1:0];
    sel_op   = bus.req_op_sel[OP_SEL_W-1:0];
    sel_pcs  = bus.req_pc_sel[PC_SEL_W-1:0];
    if (gnt_idx) begin
      sel_opd1 = bus.req_opd1[2*W-1:W];
      sel_opd2 = bus.req_opd2[2*W-1:W];
      sel_opd3 = bus.req_opd3[2*W-1:W];
      sel_opd4 = bus.req_opd4[2*W-1:W];
      sel_pc   = bus.req_pc[2*P-1:P];
      sel_mux1 = bus.req_mux1_sel[2*MUX1_SEL_W-1:MUX1_SEL_W];
      sel_mux2 = bus.req_mux2_sel[2*MUX2_SEL_W-1:MUX2_SEL_W];
      sel_op   = bus.req_op_sel[2*OP_SEL_W-1:OP_SEL_W];
      sel_pcs  = bus.req_pc_sel[2*PC_SEL_W-1:PC_SEL_W];
    end
  end

  // The issue register is only written on accept, so the ALU inputs stay quiet in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      iss_opd1     <= '0;
      iss_opd2     <= '0;
      iss_opd3     <= '0;
      iss_opd4     <= '0;
      iss_pc       <= '0;
      iss_mux1     <= '0;
      iss_mux2     <= '0;
      iss_op       <= '0;
      iss_pcs      <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_comp_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            iss_opd1 <= sel_opd1;
            iss_opd2 <= sel_opd2;
            iss_opd3 <= sel_opd3;
            iss_opd4 <= sel_opd4;
            iss_pc   <= sel_pc;
            iss_mux1 <= sel_mux1;
            iss_mux2 <= sel_mux2;
            iss_op   <= sel_op;
            iss_pcs  <= sel_pcs;
            owner_q  <= gnt_idx;
            last_q   <= gnt_idx;
            state    <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= bus.alu_result;
          rsp_comp_q   <= bus.comp_result;
          rsp_valid_q  <= idx_to_onehot(owner_q);
          state        <= RESP;
        end
        RESP: begin
          if (rsp_fire) begin
            rsp_valid_q <= '0;
            state       <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= '0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.alu_opd1        = iss_opd1;
  assign bus.alu_opd2        = iss_opd2;
  assign bus.alu_opd3        = iss_opd3;
  assign bus.alu_opd4        = iss_opd4;
  assign bus.alu_pc          = iss_pc;
  assign bus.alu_mux1_select = iss_mux1;
  assign bus.alu_mux2_select = iss_mux2;
  assign bus.alu_op_select   = iss_op;
  assign bus.alu_pc_select   = iss_pcs;

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_comp   = rsp_comp_q;

  assign dbg_state = state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU, a transaction-level reference model, directed and random stimulus.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int W = 32;
  localparam int P = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arbiter_if #(.W(W), .P(P)) bus ();
  alu_arb_state_e dbg_state;

  alu_arbiter #(.OPERAND_LENGTH(W), .PC_LENGTH(P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural shared ALU ----------------
  function automatic logic [W-1:0] alu_b(input logic [W-1:0] o2, input logic [W-1:0] o4,
                                         input logic [P-1:0] pc, input logic m1, input logic [1:0] m2);
    case (m2)
      2'd0:    return m1 ? o4 : o2;
      2'd1:    return W'(pc);
      2'd2:    return '0;
      default: return W'(1);
    endcase
  endfunction

  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [P-1:0] pc, input logic [2:0] op, input logic pcs);
    logic [W-1:0] r;
    case (op)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = a << b[4:0];
      3'd6:    r = a >> b[4:0];
      default: r = a;
    endcase
    return pcs ? r + W'(pc) : r;
  endfunction

  logic [W-1:0] env_a, env_b;
  always_comb begin
    env_a           = bus.alu_mux1_select[0] ? bus.alu_opd3 : bus.alu_opd1;
    env_b           = alu_b(bus.alu_opd2, bus.alu_opd4, bus.alu_pc, bus.alu_mux1_select[0], bus.alu_mux2_select);
    bus.alu_result  = alu_fn(env_a, env_b, bus.alu_pc, bus.alu_op_select, bus.alu_pc_select[0]);
    bus.comp_result = W'(env_a < env_b);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] o1, input logic [W-1:0] o2,
                         input logic [W-1:0] o3, input logic [W-1:0] o4, input logic [P-1:0] pc,
                         input logic m1, input logic [1:0] m2, input logic [2:0] op, input logic pcs);
    bus.req_opd1[i*W +: W]   = o1;
    bus.req_opd2[i*W +: W]   = o2;
    bus.req_opd3[i*W +: W]   = o3;
    bus.req_opd4[i*W +: W]   = o4;
    bus.req_pc[i*P +: P]     = pc;
    bus.req_mux1_sel[i]      = m1;
    bus.req_mux2_sel[i*2 +: 2] = m2;
    bus.req_op_sel[i*3 +: 3] = op;
    bus.req_pc_sel[i]        = pcs;
  endtask

  function automatic logic [W-1:0] rand_opd();
    return ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
  endfunction

  task automatic rand_req(input int i);
    set_req(i, rand_opd(), rand_opd(), rand_opd(), rand_opd(), P'($urandom),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_comp_q[$];
  int           acc_owner[$];
  int           acc_cyc[$];
  logic         m_busy, m_last, m_owner;
  int           m_phase;
  int           cyc = 0;
  int           dut_acc_cnt = 0;
  logic [1:0]   m_gnt;
  logic [W-1:0] e_opd1, e_opd2, e_opd3, e_opd4, e_a, e_b, last_opd1;
  logic [P-1:0] e_pc;
  logic [2:0]   e_op;
  logic [1:0]   e_m2;
  logic         e_m1, e_pcs;

  always @(negedge clk) begin
    if (rst_n && (bus.req_valid & bus.req_ready) != 2'b00) dut_acc_cnt++;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_req_ready", 64'(bus.req_ready), 64'(0));
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      check("rst_alu_opd1", 64'(bus.alu_opd1), 64'(0));
      check("rst_rsp_result", 64'(bus.rsp_result), 64'(0));
      check("rst_rsp_comp", 64'(bus.rsp_comp), 64'(0));
      check("rst_state", 64'(dbg_state), 64'(IDLE));
      m_busy  = 1'b0;
      m_last  = 1'b1;
      m_phase = 0;
      exp_q.delete();
      exp_comp_q.delete();
      last_opd1 = '0;
    end else begin
      cyc++;
      if (!m_busy) begin
        case (bus.req_valid)
          2'b01:   m_gnt = 2'b01;
          2'b10:   m_gnt = 2'b10;
          2'b11:   m_gnt = (m_last == 1'b1) ? 2'b01 : 2'b10;
          default: m_gnt = 2'b00;
        endcase
        check("req_ready", 64'(bus.req_ready), 64'(m_gnt));
        check("rsp_valid_idle", 64'(bus.rsp_valid), 64'(0));
        check("alu_hold_idle", 64'(bus.alu_opd1), 64'(last_opd1));
        if (m_gnt != 2'b00) begin
          m_owner = m_gnt[1];
          m_last  = m_owner;
          m_busy  = 1'b1;
          m_phase = 0;
          e_opd1  = bus.req_opd1[int'(m_owner)*W +: W];
          e_opd2  = bus.req_opd2[int'(m_owner)*W +: W];
          e_opd3  = bus.req_opd3[int'(m_owner)*W +: W];
          e_opd4  = bus.req_opd4[int'(m_owner)*W +: W];
          e_pc    = bus.req_pc[int'(m_owner)*P +: P];
          e_m1    = bus.req_mux1_sel[m_owner];
          e_m2    = bus.req_mux2_sel[int'(m_owner)*2 +: 2];
          e_op    = bus.req_op_sel[int'(m_owner)*3 +: 3];
          e_pcs   = bus.req_pc_sel[m_owner];
          e_a     = e_m1 ? e_opd3 : e_opd1;
          e_b     = alu_b(e_opd2, e_opd4, e_pc, e_m1, e_m2);
          exp_q.push_back(alu_fn(e_a, e_b, e_pc, e_op, e_pcs));
          exp_comp_q.push_back(W'(e_a < e_b));
          last_opd1 = e_opd1;
          acc_owner.push_back(int'(m_owner));
          acc_cyc.push_back(cyc);
        end
      end else begin
        m_phase++;
        check("req_ready_busy", 64'(bus.req_ready), 64'(0));
        if (m_phase == 1) begin
          check("rsp_valid_exec", 64'(bus.rsp_valid), 64'(0));
          check("alu_opd1", 64'(bus.alu_opd1), 64'(e_opd1));
          check("alu_opd2", 64'(bus.alu_opd2), 64'(e_opd2));
          check("alu_opd3", 64'(bus.alu_opd3), 64'(e_opd3));
          check("alu_opd4", 64'(bus.alu_opd4), 64'(e_opd4));
          check("alu_pc", 64'(bus.alu_pc), 64'(e_pc));
          check("alu_sels", 64'({bus.alu_mux1_select, bus.alu_mux2_select, bus.alu_op_select, bus.alu_pc_select}),
                64'({e_m1, e_m2, e_op, e_pcs}));
        end else begin
          check("rsp_valid", 64'(bus.rsp_valid), 64'(m_owner ? 2'b10 : 2'b01));
          check("rsp_result", 64'(bus.rsp_result), 64'(exp_q[0]));
          check("rsp_comp", 64'(bus.rsp_comp), 64'(exp_comp_q[0]));
          if (bus.rsp_ready[m_owner]) begin
            void'(exp_q.pop_front());
            void'(exp_comp_q.pop_front());
            m_busy = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int base, n0;

  initial begin
    rst_n            = 1'b0;
    bus.req_valid    = '0;
    bus.rsp_ready    = '0;
    bus.req_opd1     = '0;
    bus.req_opd2     = '0;
    bus.req_opd3     = '0;
    bus.req_opd4     = '0;
    bus.req_pc       = '0;
    bus.req_mux1_sel = '0;
    bus.req_mux2_sel = '0;
    bus.req_op_sel   = '0;
    bus.req_pc_sel   = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // req0 adds 5 + 7; response visible in the cycle after EXEC
    set_req(0, 32'd5, 32'd7, '0, '0, '0, 1'b0, 2'b00, 3'b000, 1'b0);
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    check("t037_exec", 64'(dbg_state), 64'(EXEC));
    tick();
    check("t037_rsp_valid", 64'(bus.rsp_valid), 64'(2'b01));
    check("t037_rsp_result", 64'(bus.rsp_result), 64'(12));
    tick();
    check("t037_idle", 64'(dbg_state), 64'(IDLE));

    // both requesters continuously valid from reset: alternate grants every 3 cycles
    do_reset();
    rand_req(0);
    rand_req(1);
    bus.rsp_ready = 2'b11;
    base          = acc_owner.size();
    bus.req_valid = 2'b11;
    repeat (13) tick();
    bus.req_valid = 2'b00;
    check("t038_count", 64'(acc_owner.size() - base >= 4), 64'(1));
    if (acc_owner.size() - base >= 4) begin
      for (int k = 0; k < 4; k++) begin
        check("t038_owner", 64'(acc_owner[base+k]), 64'(k % 2));
        if (k > 0) check("t038_gap", 64'(acc_cyc[base+k] - acc_cyc[base+k-1]), 64'(3));
      end
    end
    repeat (4) tick();

    // req1 subtracts 3 - 5 with its response held off; req0 waits meanwhile
    set_req(1, 32'd3, 32'd5, '0, '0, '0, 1'b0, 2'b00, 3'b001, 1'b0);
    bus.rsp_ready = 2'b00;
    bus.req_valid = 2'b10;
    tick();
    bus.req_valid = 2'b01;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("t039_rsp_valid", 64'(bus.rsp_valid), 64'(2'b10));
      check("t039_rsp_result", 64'(bus.rsp_result), 64'(32'hFFFF_FFFE));
      check("t039_req_ready", 64'(bus.req_ready), 64'(2'b00));
      tick();
    end
    bus.rsp_ready = 2'b01;
    tick();
    check("t039_nonowner_ignored", 64'(bus.rsp_valid), 64'(2'b10));
    check("t039_result_stable", 64'(bus.rsp_result), 64'(32'hFFFF_FFFE));
    bus.rsp_ready = 2'b10;
    bus.req_valid = 2'b00;
    tick();
    check("t039_released", 64'(bus.rsp_valid), 64'(2'b00));
    tick();

    // req0 compare of opd3/opd4 through mux1
    set_req(0, '0, '0, 32'd2, 32'd9, '0, 1'b1, 2'b00, 3'b000, 1'b0);
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    check("t040_alu_opd3", 64'(bus.alu_opd3), 64'(2));
    check("t040_alu_opd4", 64'(bus.alu_opd4), 64'(9));
    check("t040_mux1", 64'(bus.alu_mux1_select), 64'(1));
    tick();
    check("t040_rsp_comp", 64'(bus.rsp_comp), 64'(1));
    check("t040_rsp_valid", 64'(bus.rsp_valid), 64'(2'b01));
    tick();

    // reset pulse while a req0 op is in EXEC discards it
    rand_req(0);
    bus.req_valid = 2'b01;
    tick();
    check("t041_exec", 64'(dbg_state), 64'(EXEC));
    rst_n         = 1'b0;
    bus.req_valid = 2'b00;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t041_no_rsp", 64'(bus.rsp_valid), 64'(0));
    end
    bus.req_valid = 2'b11;
    #1;
    check("t041_tie_to_req0", 64'(bus.req_ready), 64'(2'b01));
    tick();
    bus.req_valid = 2'b00;
    repeat (4) tick();

    // req0 raises then drops valid while req1 is busy
    rand_req(1);
    bus.rsp_ready = 2'b00;
    bus.req_valid = 2'b10;
    tick();
    bus.req_valid = 2'b00;
    tick();
    n0            = dut_acc_cnt;
    bus.req_valid = 2'b01;
    tick();
    tick();
    bus.req_valid = 2'b00;
    tick();
    bus.rsp_ready = 2'b11;
    repeat (4) tick();
    check("t042_no_issue", 64'(dut_acc_cnt), 64'(n0));
    check("t042_idle", 64'(dbg_state), 64'(IDLE));
    bus.req_valid = 2'b11;
    #1;
    check("t042_tie_to_req0", 64'(bus.req_ready), 64'(2'b01));
    tick();
    bus.req_valid = 2'b00;
    repeat (4) tick();

    // random traffic: valids, operands and response back-pressure all vary per cycle
    for (int n = 0; n < 400; n++) begin
      bus.req_valid = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) rand_req(0);
      if ($urandom_range(0, 1) == 1) rand_req(1);
      bus.rsp_ready = 2'($urandom_range(0, 3));
      tick();
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    repeat (5) tick();
    check("drain_idle", 64'(dbg_state), 64'(IDLE));
    check("drain_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
